// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
//
// Holds the architectural PC, issues one request per instruction to a
// variable-latency instruction memory, registers the returned word and
// presents it (with its PC) until the datapath retires it. It then picks the
// next PC from PCsel / alu_result. Faults (memory timeout, misaligned
// redirect, non-32-bit encoding) are sticky until reset.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req          one-cycle fetch request pulse (FETCH state)
//   imem_addr         fetch address, always equal to pc
//   imem_rdata        instruction word, valid with imem_rvalid
//   imem_rvalid       response strobe from instruction memory
//   retire            datapath finished current instruction (VALID only)
//   PCsel             1 = redirect to alu_result on retire
//   alu_result        branch/jump target
//   instruction       registered instruction word
//   pc, pc_plus4      PC of presented instruction and pc + 4
//   instr_valid       instruction/pc are valid
//   fault             sticky fault flag
//   fault_cause       00 none, 01 timeout, 10 misaligned, 11 illegal length
//   instret           retired instruction count
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        retire,
  input  logic        PCsel,
  input  logic [31:0] alu_result,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  wait_cnt;
  logic [1:0]  cause_next;
  logic        capture;
  logic        advance;
  logic [31:0] target;

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  // The request is qualified with rst_n so no pulse escapes while reset is held.
  assign imem_req    = (state == S_FETCH) && rst_n;
  assign instr_valid = (state == S_VALID);

  always_comb begin
    state_next = state;
    cause_next = 2'b00;
    capture    = 1'b0;
    advance    = 1'b0;
    // Bit 0 of a redirect is always cleared, matching JALR semantics.
    target     = PCsel ? (alu_result & ~32'd1) : pc_plus4;
    case (state)
      S_FETCH: state_next = S_WAIT;
      S_WAIT: begin
        // A response wins over a timeout landing in the same cycle.
        if (imem_rvalid) begin
          if (imem_rdata[1:0] == 2'b11) begin
            capture    = 1'b1;
            state_next = S_VALID;
          end else begin
            cause_next = 2'b11;
            state_next = S_FAULT;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          cause_next = 2'b01;
          state_next = S_FAULT;
        end
      end
      S_VALID: begin
        if (retire) begin
          advance = 1'b1;
          if (PCsel && target[1]) begin
            cause_next = 2'b10;
            state_next = S_FAULT;
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instruction <= 32'h0000_0013;
      instret     <= 32'd0;
      wait_cnt    <= 8'd0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      if (state == S_FETCH) begin
        wait_cnt <= 8'd0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (capture) begin
        instruction <= imem_rdata;
      end
      // A misaligned redirect still updates pc and counts as retired.
      if (advance) begin
        pc      <= target;
        instret <= instret + 32'd1;
      end
      // Cause is latched only on entry, so FAULT never overwrites it.
      if ((state_next == S_FAULT) && (state != S_FAULT)) begin
        fault       <= 1'b1;
        fault_cause <= cause_next;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed, table-driven bench for fetch_unit.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        retire;
  logic        PCsel;
  logic [31:0] alu_result;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .retire      (retire),
    .PCsel       (PCsel),
    .alu_result  (alu_result),
    .instruction (instruction),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .fault       (fault),
    .fault_cause (fault_cause),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wait_n;
    logic [31:0] rdata;
    logic        pcsel;
    logic [31:0] alu;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc4;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    retire      = 1'b0;
    PCsel       = 1'b0;
    alu_result  = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // One full transaction starting in FETCH; returns just after the retire edge.
  task automatic do_instr(input int wait_n, input logic [31:0] rdata, input logic pcsel,
                          input logic [31:0] alu, input logic [31:0] exp_addr,
                          input logic [31:0] exp_pc4);
    chk("req_in_fetch", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, exp_addr);
    @(negedge clk);
    chk("req_dropped", 32'(imem_req), 32'd0);
    for (int i = 0; i < wait_n; i++) @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = rdata;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    chk("valid_up", 32'(instr_valid), 32'd1);
    chk("instr", instruction, rdata);
    chk("pc", pc, exp_addr);
    chk("pc_plus4", pc_plus4, exp_pc4);
    @(negedge clk);
    chk("valid_hold", 32'(instr_valid), 32'd1);
    chk("instr_hold", instruction, rdata);
    retire     = 1'b1;
    PCsel      = pcsel;
    alu_result = alu;
    @(negedge clk);
    retire     = 1'b0;
    PCsel      = 1'b0;
    alu_result = 32'h0;
    chk("valid_fall", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 32'h0050_0093, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004, 32'h0000_0004};
    vecs[1] = '{0, 32'h0000_0013, 1'b0, 32'h0,         32'h0000_0004, 32'h0000_0008, 32'h0000_0008};
    vecs[2] = '{2, 32'h0000_0063, 1'b1, 32'h0000_0040, 32'h0000_0008, 32'h0000_000C, 32'h0000_0040};
    vecs[3] = '{0, 32'h0000_006F, 1'b1, 32'h0000_0041, 32'h0000_0040, 32'h0000_0044, 32'h0000_0040};
    vecs[4] = '{3, 32'h00A0_0113, 1'b1, 32'hFFFF_FFFC, 32'h0000_0040, 32'h0000_0044, 32'hFFFF_FFFC};
    vecs[5] = '{0, 32'h0000_0013, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};

    // Reset state while reset is held
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    retire      = 1'b0;
    PCsel       = 1'b0;
    alu_result  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", {30'd0, fault_cause} | 32'(fault), 32'd0);
    chk("rst_instret", instret, 32'd0);
    rst_n = 1'b1;
    #1;

    // Table: sequential, branch, bit-0 clearing, wrap at 0xFFFFFFFC
    for (int v = 0; v < 6; v++) begin
      do_instr(vecs[v].wait_n, vecs[v].rdata, vecs[v].pcsel, vecs[v].alu,
               vecs[v].exp_addr, vecs[v].exp_pc4);
      chk("tbl_next_addr", imem_addr, vecs[v].exp_next);
      chk("tbl_instret", instret, 32'(v + 1));
      chk("tbl_no_fault", 32'(fault), 32'd0);
    end

    // Misaligned redirect
    do_instr(0, 32'h0000_0013, 1'b1, 32'h0000_0042, 32'h0000_0000, 32'h0000_0004);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_cause", 32'(fault_cause), 32'd2);
    chk("mis_pc", pc, 32'h0000_0042);
    chk("mis_instret", instret, 32'd7);
    retire = 1'b1;
    PCsel  = 1'b1;
    alu_result = 32'h0000_0100;
    for (int i = 0; i < 5; i++) begin
      chk("mis_no_req", 32'(imem_req), 32'd0);
      @(negedge clk);
    end
    retire = 1'b0;
    PCsel  = 1'b0;
    chk("mis_pc_frozen", pc, 32'h0000_0042);
    chk("mis_instret_frozen", instret, 32'd7);

    // Timeout: exactly 16 WAIT cycles, then cause 01
    do_reset();
    chk("to_req", 32'(imem_req), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1 || k == 16) chk("to_wait_no_fault", 32'(fault), 32'd0);
    end
    @(negedge clk);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_cause", 32'(fault_cause), 32'd1);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    @(negedge clk);
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("to_late_valid", 32'(instr_valid), 32'd0);
    chk("to_late_instr", instruction, 32'h0000_0013);
    chk("to_cause_kept", 32'(fault_cause), 32'd1);

    // Illegal length encoding after one good instruction
    do_reset();
    do_instr(0, 32'h0050_0093, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0004);
    chk("ill_addr", imem_addr, 32'h0000_0004);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_4501;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("ill_fault", 32'(fault), 32'd1);
    chk("ill_cause", 32'(fault_cause), 32'd3);
    chk("ill_valid", 32'(instr_valid), 32'd0);
    chk("ill_instr", instruction, 32'h0050_0093);
    chk("ill_pc", pc, 32'h0000_0004);
    @(negedge clk);
    chk("ill_no_req", 32'(imem_req), 32'd0);

    // Async reset in VALID with retire asserted
    do_reset();
    do_instr(0, 32'h0050_0093, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0004);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("ar_in_valid", 32'(instr_valid), 32'd1);
    chk("ar_pc_before", pc, 32'h0000_0004);
    retire = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pc", pc, 32'h0);
    chk("ar_instret", instret, 32'd0);
    chk("ar_valid", 32'(instr_valid), 32'd0);
    chk("ar_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    retire = 1'b0;
    rst_n  = 1'b1;
    #1;
    do_instr(0, 32'h0000_0013, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0004);
    chk("ar_restart_instret", instret, 32'd1);
    chk("ar_restart_addr", imem_addr, 32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit and datapath.
- Holds the architectural PC and issues one request per instruction to a variable-latency instruction memory.
- Registers the returned word, presents it with its PC until the datapath signals retirement, then computes the next PC from the control unit's PCsel and the ALU result.
- Detects memory timeout, misaligned redirect and non-32-bit encodings, and counts retired instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles spent in WAIT before a timeout fault (range 1..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  one-cycle fetch request pulse
imem_addr  output  32  fetch address, equals pc
imem_rdata  input  32  instruction word, valid when imem_rvalid=1
imem_rvalid  input  1  response strobe from instruction memory
retire  input  1  datapath finished current instruction; sampled only in VALID
PCsel  input  1  from control unit: 1 = redirect to alu_result
alu_result  input  32  branch/jump target from ALU
instruction  output  32  registered instruction to control unit/datapath
pc  output  32  PC of the presented instruction
pc_plus4  output  32  pc + 4 (mod 2^32), for WBsel=2'b10 link value
instr_valid  output  1  instruction/pc are valid
fault  output  1  sticky fault flag
fault_cause  output  2  00 none, 01 imem timeout, 10 misaligned target, 11 illegal length encoding
instret  output  32  retired instruction count

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=FETCH, pc=RESET_PC, instruction=32'h0000_0013 (NOP), instr_valid=0.
  - fault=0, fault_cause=00, instret=0, wait counter=0.
  - imem_req=0 while reset is asserted.
- States: FETCH, WAIT, VALID, FAULT.
- FETCH:
  - imem_req=1 for exactly this cycle; imem_addr=pc.
  - Next state WAIT, wait counter cleared.
  - imem_rvalid is ignored in FETCH.
- WAIT:
  - imem_req=0; imem_addr holds pc; counter increments each cycle.
  - On imem_rvalid=1 with imem_rdata[1:0]==2'b11: capture instruction, next VALID.
  - On imem_rvalid=1 with imem_rdata[1:0]!=2'b11: next FAULT, cause 11, instruction not updated.
  - rvalid takes priority over timeout in the same cycle.
  - If the counter reaches TIMEOUT with no rvalid: next FAULT, cause 01.
- VALID:
  - instr_valid=1; instruction and pc held stable until retire=1.
  - On retire, target = PCsel ? {alu_result[31:1],1'b0} : pc+4. Bit 0 is always cleared, per JALR.
  - If PCsel=1 and target[1]=1: pc<=target, instret+1, next FAULT, cause 10.
  - Otherwise: pc<=target, instret+1, next FETCH.
  - instr_valid falls in the cycle after retire.
- FAULT:
  - Absorbing until reset; imem_req=0, instr_valid=0.
  - pc and instruction frozen; retire and imem_rvalid ignored.
  - fault=1, fault_cause latched on entry and never overwritten.
- Latency: minimum 3 cycles per instruction (FETCH, WAIT with rvalid, VALID with retire). The first instruction_valid is at the earliest 2 cycles after reset release.
- retire is ignored outside VALID. Late or stray imem_rvalid outside WAIT is ignored.
- instret and pc+4 wrap modulo 2^32; PC 32'hFFFF_FFFC + 4 yields 0 with no fault.
- Reset mid-operation (any state) returns immediately to reset values. A pending memory response after reset is ignored unless it arrives in WAIT of the new fetch.

Test Plan:
- Reset release, memory returns 32'h00500093 after 1 wait cycle, retire with PCsel=0 → imem_addr=0, instruction=32'h00500093, instr_valid high 1+ cycles, next imem_addr=4, instret=1.
- Branch taken: PC=8, PCsel=1, alu_result=32'h0000_0040 on retire → next imem_req with addr 0x40. Repeat with alu_result=32'h0000_0041 → addr 0x40 (bit 0 cleared), no fault.
- Misaligned: PCsel=1, alu_result=32'h0000_0042 on retire → fault=1, fault_cause=10, pc=0x42, instret incremented, no further imem_req.
- Timeout: TIMEOUT=16, imem_rvalid never asserted → exactly 16 WAIT cycles, then fault=1, cause=01; an rvalid arriving afterwards is ignored.
- Illegal encoding: imem_rdata=32'h0000_4501 → fault=1, cause=11, instr_valid never asserted, instruction stays at previous value.
- Async reset asserted in VALID with retire=1 in the same cycle → pc=RESET_PC, instret=0, instr_valid=0 immediately; fetch restarts at RESET_PC after release.
